// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the IF fetch controller: reset constants,
// FSM state encoding, IF/ID register operations and the IF/ID payload.
package if_fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;  // sll $0,$0,0

  // Fetch FSM states
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } fetch_state_e;

  // What the IF/ID register does on the next edge
  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_LOAD   = 2'd1,
    IFID_BUBBLE = 2'd2
  } ifid_op_e;

  // Payload carried into ID (valid is tracked separately)
  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } ifid_word_t;

  // Sequential PC increment, 32-bit modulo so 0xFFFF_FFFC wraps to 0
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch controller
// (master) and the imem/icache (slave). One outstanding request at a time.
interface if_fetch_ctrl_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/if_fetch_ctrl_ifid_reg.sv
// IF/ID pipeline register. The fetch FSM decides each cycle whether it
// loads a fetched word, holds (ID stalled) or takes a bubble.
module ifid_reg
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  ifid_op_e    op_i,
  input  ifid_word_t  word_i,
  output logic        valid_o,
  output logic [31:0] pc4_o,
  output logic [31:0] instr_o
);

  logic       valid_q;
  ifid_word_t word_q;

  // Load / hold / bubble update; a bubble is an invalid NOP with pc4 cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      word_q.pc4   <= 32'h0;
      word_q.instr <= NOP_INSTR;
    end else begin
      case (op_i)
        IFID_LOAD: begin
          valid_q <= 1'b1;
          word_q  <= word_i;
        end
        IFID_BUBBLE: begin
          valid_q      <= 1'b0;
          word_q.pc4   <= 32'h0;
          word_q.instr <= NOP_INSTR;
        end
        default: begin
        end
      endcase
    end
  end

  assign valid_o = valid_q;
  assign pc4_o   = word_q.pc4;
  assign instr_o = word_q.instr;

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF stage sequential half: PC register, imem request handshake and the
// IF/ID register with stall/flush handling. FETCH issues the request for
// pc; HOLD parks a word that arrived while ID was stalled; DROP waits out
// a request that was in flight when a redirect arrived, keeping its
// address stable so the bus never sees a mid-transaction change.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            pc_next_i,
  input  logic                   stall_i,
  input  logic                   flush_i,
  output logic [31:0]            pc_o,
  if_fetch_ctrl_if.master        imem,
  output logic                   ifid_valid_o,
  output logic [31:0]            ifid_pc4_o,
  output logic [31:0]            ifid_instr_o
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  drop_addr_q;
  ifid_word_t   buf_q;
  ifid_op_e     ifid_op_d;
  ifid_word_t   ifid_word_d;
  logic         ack;

  assign ack = imem.imem_ack;

  // Decide the IF/ID register action for this cycle; flush beats stall
  always_comb begin
    ifid_op_d         = IFID_HOLD;
    ifid_word_d.pc4   = pc_plus4(pc_q);
    ifid_word_d.instr = imem.imem_rdata;
    case (state_q)
      S_FETCH: begin
        if (flush_i)
          ifid_op_d = IFID_BUBBLE;
        else if (stall_i)
          ifid_op_d = IFID_HOLD;
        else if (ack)
          ifid_op_d = IFID_LOAD;
        else
          ifid_op_d = IFID_BUBBLE;
      end
      S_HOLD: begin
        if (flush_i) begin
          ifid_op_d = IFID_BUBBLE;
        end else if (!stall_i) begin
          ifid_op_d   = IFID_LOAD;
          ifid_word_d = buf_q;
        end
      end
      default: ifid_op_d = IFID_BUBBLE;
    endcase
  end

  // Fetch FSM: PC, hold buffer, drop address and state transitions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      drop_addr_q <= 32'h0;
      buf_q.pc4   <= 32'h0;
      buf_q.instr <= NOP_INSTR;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (flush_i) begin
            pc_q <= pc_next_i;
            if (!ack) begin
              drop_addr_q <= pc_q;
              state_q     <= S_DROP;
            end
          end else if (ack) begin
            if (stall_i) begin
              buf_q.pc4   <= pc_plus4(pc_q);
              buf_q.instr <= imem.imem_rdata;
              state_q     <= S_HOLD;
            end else begin
              pc_q <= pc_next_i;
            end
          end
        end
        S_HOLD: begin
          if (flush_i) begin
            pc_q        <= pc_next_i;
            buf_q.pc4   <= 32'h0;
            buf_q.instr <= NOP_INSTR;
            state_q     <= S_FETCH;
          end else if (!stall_i) begin
            pc_q    <= pc_next_i;
            state_q <= S_FETCH;
          end
        end
        S_DROP: begin
          if (flush_i)
            pc_q <= pc_next_i;
          if (ack)
            state_q <= S_FETCH;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Request is idle in HOLD and forced low while reset is asserted
  assign imem.imem_req  = ~rst & (state_q != S_HOLD);
  assign imem.imem_addr = (state_q == S_DROP) ? drop_addr_q : pc_q;
  assign pc_o           = pc_q;

  ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk     (clk),
    .rst     (rst),
    .op_i    (ifid_op_d),
    .word_i  (ifid_word_d),
    .valid_o (ifid_valid_o),
    .pc4_o   (ifid_pc4_o),
    .instr_o (ifid_instr_o)
  );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Testbench for if_fetch_ctrl: scenario tasks drive the fetch bus and
// check IF/ID against a queue of expected words.
module tb_if_fetch_ctrl;
  import if_fetch_ctrl_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, redirect;
  logic [31:0] target;
  logic [31:0] pc, pc_next;
  logic        ifid_valid;
  logic [31:0] ifid_pc4, ifid_instr;
  int          checks = 0;
  int          failures = 0;
  ifid_word_t  exp_q[$];
  ifid_word_t  e;

  if_fetch_ctrl_if bus ();

  // Stand-in for the IF next-PC mux: sequential unless redirecting
  assign pc_next = redirect ? target : pc + 32'd4;

  if_fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .pc_next_i    (pc_next),
    .stall_i      (stall),
    .flush_i      (flush),
    .pc_o         (pc),
    .imem         (bus),
    .ifid_valid_o (ifid_valid),
    .ifid_pc4_o   (ifid_pc4),
    .ifid_instr_o (ifid_instr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; target = 32'h0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic pop_check(input string name);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL %s: scoreboard empty, got valid=%b pc4=%h instr=%h", name, ifid_valid, ifid_pc4, ifid_instr);
    end else begin
      e = exp_q.pop_front();
      if ({ifid_valid, ifid_pc4, ifid_instr} !== {1'b1, e.pc4, e.instr}) begin
        failures++;
        $display("[TB] FAIL %s: got valid=%b pc4=%h instr=%h expected valid=1 pc4=%h instr=%h",
                 name, ifid_valid, ifid_pc4, ifid_instr, e.pc4, e.instr);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1111_1111;
    tick();
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({pc, bus.imem_req, ifid_valid, ifid_pc4, ifid_instr} !== {32'h0, 1'b0, 1'b0, 32'h0, NOP}) begin
      failures++;
      $display("[TB] FAIL reset_async: got pc=%h req=%b valid=%b pc4=%h instr=%h expected 0/0/0/0/%h",
               pc, bus.imem_req, ifid_valid, ifid_pc4, ifid_instr, NOP);
    end
    tick();
    checks++;
    if (bus.imem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_req_held: got req=%b expected 0", bus.imem_req);
    end
    bus.imem_ack = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
      failures++;
      $display("[TB] FAIL reset_release: got req=%b addr=%h expected req=1 addr=0", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] words [3];
    words[0] = 32'h2008_0001; words[1] = 32'h2009_0002; words[2] = 32'h200A_0003;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      bus.imem_ack = 1'b1; bus.imem_rdata = words[k];
      checks++;
      if (bus.imem_addr !== 32'(4 * k)) begin
        failures++;
        $display("[TB] FAIL zw_addr%0d: got %h expected %h", k, bus.imem_addr, 32'(4 * k));
      end
      exp_q.push_back('{pc4: 32'(4 * k + 4), instr: words[k]});
      tick();
      pop_check($sformatf("zw_ifid%0d", k));
    end
    bus.imem_ack = 1'b0;
    tick();
    checks++;
    if ({ifid_valid, ifid_pc4, ifid_instr} !== {1'b0, 32'h0, NOP}) begin
      failures++;
      $display("[TB] FAIL zw_bubble: got valid=%b pc4=%h instr=%h expected bubble", ifid_valid, ifid_pc4, ifid_instr);
    end
  endtask

  task automatic test_stall_on_ack();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h3000_0000 + 32'(k);
      exp_q.push_back('{pc4: 32'(4 * k + 4), instr: 32'h3000_0000 + 32'(k)});
      tick();
      pop_check($sformatf("st_pre%0d", k));
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h3000_00AA; stall = 1'b1;
    checks++;
    if (bus.imem_addr !== 32'h8) begin
      failures++;
      $display("[TB] FAIL st_addr: got %h expected 00000008", bus.imem_addr);
    end
    exp_q.push_back('{pc4: 32'hC, instr: 32'h3000_00AA});
    tick();
    bus.imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.imem_req, ifid_valid, ifid_pc4, ifid_instr} !== {1'b0, 1'b1, 32'h8, 32'h3000_0001}) begin
        failures++;
        $display("[TB] FAIL st_hold%0d: got req=%b valid=%b pc4=%h instr=%h expected 0/1/8/30000001",
                 i, bus.imem_req, ifid_valid, ifid_pc4, ifid_instr);
      end
      if (i == 2) stall = 1'b0;
      tick();
    end
    pop_check("st_release");
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'hC}) begin
      failures++;
      $display("[TB] FAIL st_next_addr: got req=%b addr=%h expected 1/0000000c", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_flush_on_miss();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h4000_0000 + 32'(k);
      exp_q.push_back('{pc4: 32'(4 * k + 4), instr: 32'h4000_0000 + 32'(k)});
      tick();
      pop_check($sformatf("fm_pre%0d", k));
    end
    bus.imem_ack = 1'b0;
    tick();
    flush = 1'b1; redirect = 1'b1; target = 32'h40;
    tick();
    flush = 1'b0; redirect = 1'b0;
    checks++;
    if ({ifid_valid, pc, bus.imem_req, bus.imem_addr} !== {1'b0, 32'h40, 1'b1, 32'h10}) begin
      failures++;
      $display("[TB] FAIL fm_drop: got valid=%b pc=%h req=%b addr=%h expected 0/40/1/10",
               ifid_valid, pc, bus.imem_req, bus.imem_addr);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({ifid_valid, bus.imem_addr} !== {1'b0, 32'h10}) begin
        failures++;
        $display("[TB] FAIL fm_wait%0d: got valid=%b addr=%h expected 0/10", i, ifid_valid, bus.imem_addr);
      end
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.imem_ack = 1'b0;
    checks++;
    if ({ifid_valid, ifid_instr, bus.imem_addr} !== {1'b0, NOP, 32'h40}) begin
      failures++;
      $display("[TB] FAIL fm_discard: got valid=%b instr=%h addr=%h expected 0/%h/40",
               ifid_valid, ifid_instr, bus.imem_addr, NOP);
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2140_0044;
    exp_q.push_back('{pc4: 32'h44, instr: 32'h2140_0044});
    tick();
    bus.imem_ack = 1'b0;
    pop_check("fm_target");
  endtask

  task automatic test_flush_stall_hold();
    do_reset();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBBBB_0000; stall = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fs_hold_req: got req=%b expected 0", bus.imem_req);
    end
    flush = 1'b1; redirect = 1'b1; target = 32'h80;
    tick();
    flush = 1'b0; redirect = 1'b0; stall = 1'b0;
    checks++;
    if ({ifid_valid, ifid_pc4, ifid_instr, pc, bus.imem_req, bus.imem_addr} !==
        {1'b0, 32'h0, NOP, 32'h80, 1'b1, 32'h80}) begin
      failures++;
      $display("[TB] FAIL fs_bubble: got valid=%b pc4=%h instr=%h pc=%h req=%b addr=%h expected 0/0/%h/80/1/80",
               ifid_valid, ifid_pc4, ifid_instr, pc, bus.imem_req, bus.imem_addr, NOP);
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2000_0080;
    exp_q.push_back('{pc4: 32'h84, instr: 32'h2000_0080});
    tick();
    bus.imem_ack = 1'b0;
    pop_check("fs_target");
    tick();
    checks++;
    if ({ifid_valid, ifid_instr} !== {1'b0, NOP}) begin
      failures++;
      $display("[TB] FAIL fs_no_stale: got valid=%b instr=%h expected 0/%h", ifid_valid, ifid_instr, NOP);
    end
  endtask

  task automatic test_wrap_and_drop_reset();
    do_reset();
    flush = 1'b1; redirect = 1'b1; target = 32'hFFFF_FFFC;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h5555_5555;
    tick();
    flush = 1'b0; redirect = 1'b0;
    checks++;
    if ({pc, ifid_valid} !== {32'hFFFF_FFFC, 1'b0}) begin
      failures++;
      $display("[TB] FAIL wr_redirect: got pc=%h valid=%b expected fffffffc/0", pc, ifid_valid);
    end
    bus.imem_rdata = 32'h2222_FFFF;
    exp_q.push_back('{pc4: 32'h0, instr: 32'h2222_FFFF});
    tick();
    bus.imem_ack = 1'b0;
    pop_check("wr_pc4");
    checks++;
    if (pc !== 32'h0) begin
      failures++;
      $display("[TB] FAIL wr_pc: got %h expected 00000000", pc);
    end
    flush = 1'b1; redirect = 1'b1; target = 32'h100;
    tick();
    target = 32'h200;
    tick();
    flush = 1'b0; redirect = 1'b0;
    checks++;
    if ({pc, bus.imem_req, bus.imem_addr} !== {32'h200, 1'b1, 32'h0}) begin
      failures++;
      $display("[TB] FAIL wr_drop_reflush: got pc=%h req=%b addr=%h expected 200/1/0", pc, bus.imem_req, bus.imem_addr);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({pc, bus.imem_req, ifid_valid, ifid_instr} !== {32'h0, 1'b0, 1'b0, NOP}) begin
      failures++;
      $display("[TB] FAIL wr_drop_rst: got pc=%h req=%b valid=%b instr=%h expected 0/0/0/%h",
               pc, bus.imem_req, ifid_valid, ifid_instr, NOP);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
      failures++;
      $display("[TB] FAIL wr_rst_release: got req=%b addr=%h expected 1/0", bus.imem_req, bus.imem_addr);
    end
  endtask

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; target = 32'h0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
    test_reset();
    test_zero_wait();
    test_stall_on_ack();
    test_flush_on_miss();
    test_flush_stall_hold();
    test_wrap_and_drop_reset();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
